// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, hex glyph table and decoder.
// The display encoder uses the same table, so both ends agree on every glyph.
package seg7_pkg;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;
   localparam int unsigned SEG_W = 7;

   // gfedcba, active-high
   localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
   localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
   localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
   localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
   localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
   localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

   typedef enum logic {
      FILT_IDLE = 1'b0,
      FILT_CAND = 1'b1
   } filt_state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] digit;
   } seg7_dec_t;

   function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] code);
      seg7_dec_t r;
      r.valid = 1'b1;
      r.digit = 4'h0;
      case (code)
         GLYPH_0: r.digit = 4'h0;
         GLYPH_1: r.digit = 4'h1;
         GLYPH_2: r.digit = 4'h2;
         GLYPH_3: r.digit = 4'h3;
         GLYPH_4: r.digit = 4'h4;
         GLYPH_5: r.digit = 4'h5;
         GLYPH_6: r.digit = 4'h6;
         GLYPH_7: r.digit = 4'h7;
         GLYPH_8: r.digit = 4'h8;
         GLYPH_9: r.digit = 4'h9;
         GLYPH_A: r.digit = 4'hA;
         GLYPH_B: r.digit = 4'hB;
         GLYPH_C: r.digit = 4'hC;
         GLYPH_D: r.digit = 4'hD;
         GLYPH_E: r.digit = 4'hE;
         GLYPH_F: r.digit = 4'hF;
         default: begin
            r.valid = 1'b0;
            r.digit = 4'h0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Input register plus glitch filter: accepts a new segment pattern once it has
// been sampled STABLE_CYCLES times in a row and differs from the current code.
//
// state     | meaning
// FILT_IDLE | sampled pattern equals the accepted code, nothing pending
// FILT_CAND | a different pattern is being timed for stability
module seg7_stable_filter
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEG_W-1:0] segments_i,
   input  logic [SEG_W-1:0] seg_code_i,
   output logic             accept_o,
   output logic [SEG_W-1:0] pattern_o
);

   localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

   filt_state_e      state_q;
   logic [SEG_W-1:0] seg_q;
   logic [SEG_W-1:0] cand_q;
   logic [7:0]       cnt_q;

   logic             differs;
   logic             same_cand;
   logic [7:0]       run_d;

   // run_d is the length of the current run including this sample, so the
   // top can register the accepted pattern on the very edge the run completes.
   always_comb begin
      differs   = (seg_q != seg_code_i);
      same_cand = (state_q == FILT_CAND) && (seg_q == cand_q);
      run_d     = same_cand ? (cnt_q + 8'd1) : 8'd1;
      accept_o  = differs && (run_d == STABLE_L);
      pattern_o = seg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILT_IDLE;
         seg_q   <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         seg_q <= segments_i;
         if (!differs || accept_o) begin
            state_q <= FILT_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= FILT_CAND;
            cand_q  <= seg_q;
            cnt_q   <= run_d;
         end
      end
   end

endmodule

// File: rtl/seg7_monitor.sv
// Readback monitor for the 7-segment bus: filters, decodes, times and counts
// accepted display patterns.
module seg7_monitor
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned INTERVAL_W    = 24,
   parameter int unsigned COUNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEG_W-1:0]      segments_in,
   output logic [SEG_W-1:0]      seg_code,
   output logic [3:0]            digit,
   output logic                  digit_valid,
   output logic                  change_pulse,
   output logic [INTERVAL_W-1:0] interval,
   output logic                  interval_valid,
   output logic                  interval_sat,
   output logic [COUNT_W-1:0]    change_count
);

   localparam logic [INTERVAL_W-1:0] IVL_ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};
   localparam logic [INTERVAL_W-1:0] IVL_MAX = {INTERVAL_W{1'b1}};
   localparam logic [COUNT_W-1:0]    CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic             accept;
   logic [SEG_W-1:0] pattern;
   seg7_dec_t        dec;

   logic [SEG_W-1:0]      seg_code_q;
   logic [3:0]            digit_q;
   logic                  digit_valid_q;
   logic                  change_pulse_q;
   logic [INTERVAL_W-1:0] interval_q;
   logic                  interval_valid_q;
   logic                  interval_sat_q;
   logic [COUNT_W-1:0]    change_count_q;
   logic [INTERVAL_W-1:0] ivl_cnt_q;
   logic                  have_ref_q;

   seg7_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .segments_i (segments_in),
      .seg_code_i (seg_code_q),
      .accept_o   (accept),
      .pattern_o  (pattern)
   );

   always_comb dec = seg7_decode(pattern);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_code_q       <= '0;
         digit_q          <= '0;
         digit_valid_q    <= 1'b0;
         change_pulse_q   <= 1'b0;
         interval_q       <= '0;
         interval_valid_q <= 1'b0;
         interval_sat_q   <= 1'b0;
         change_count_q   <= '0;
         ivl_cnt_q        <= '0;
         have_ref_q       <= 1'b0;
      end else begin
         change_pulse_q <= accept;
         if (accept) begin
            seg_code_q     <= pattern;
            digit_q        <= dec.digit;
            digit_valid_q  <= dec.valid;
            change_count_q <= change_count_q + CNT_ONE;
            ivl_cnt_q      <= '0;
            have_ref_q     <= 1'b1;
            // The first acceptance only starts the timebase; no interval yet.
            if (have_ref_q) begin
               interval_valid_q <= 1'b1;
               if (ivl_cnt_q == IVL_MAX) begin
                  interval_q     <= IVL_MAX;
                  interval_sat_q <= 1'b1;
               end else begin
                  interval_q     <= ivl_cnt_q + IVL_ONE;
                  interval_sat_q <= 1'b0;
               end
            end
         end else if (ivl_cnt_q != IVL_MAX) begin
            ivl_cnt_q <= ivl_cnt_q + IVL_ONE;
         end
      end
   end

   assign seg_code       = seg_code_q;
   assign digit          = digit_q;
   assign digit_valid    = digit_valid_q;
   assign change_pulse   = change_pulse_q;
   assign interval       = interval_q;
   assign interval_valid = interval_valid_q;
   assign interval_sat   = interval_sat_q;
   assign change_count   = change_count_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: a default instance plus a narrow one
// (8-bit interval, 2-bit change count) driven by the same segment stream.
module tb_seg7_monitor;

   logic        clk;
   logic        rst_n;
   logic [6:0]  segments_in;

   logic [6:0]  seg_code;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        change_pulse;
   logic [23:0] interval;
   logic        interval_valid;
   logic        interval_sat;
   logic [15:0] change_count;

   logic [6:0]  n_seg_code;
   logic [3:0]  n_digit;
   logic        n_digit_valid;
   logic        n_change_pulse;
   logic [7:0]  n_interval;
   logic        n_interval_valid;
   logic        n_interval_sat;
   logic [1:0]  n_change_count;

   int compared;
   int mismatched;
   int cyc;
   int t_drive;

   seg7_monitor #(.STABLE_CYCLES(4), .INTERVAL_W(24), .COUNT_W(16)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .segments_in    (segments_in),
      .seg_code       (seg_code),
      .digit          (digit),
      .digit_valid    (digit_valid),
      .change_pulse   (change_pulse),
      .interval       (interval),
      .interval_valid (interval_valid),
      .interval_sat   (interval_sat),
      .change_count   (change_count)
   );

   seg7_monitor #(.STABLE_CYCLES(4), .INTERVAL_W(8), .COUNT_W(2)) u_narrow (
      .clk            (clk),
      .rst_n          (rst_n),
      .segments_in    (segments_in),
      .seg_code       (n_seg_code),
      .digit          (n_digit),
      .digit_valid    (n_digit_valid),
      .change_pulse   (n_change_pulse),
      .interval       (n_interval),
      .interval_valid (n_interval_valid),
      .interval_sat   (n_interval_sat),
      .change_count   (n_change_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Steps negedges until change_pulse is seen; edges = -1 when the budget expires.
   task automatic wait_pulse(input int budget, output int edges);
      edges = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (change_pulse) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int pulses;
      rst_n = 1'b0;
      segments_in = 7'h00;
      repeat (3) @(negedge clk);
      compared++;
      if (seg_code !== 7'h00 || digit !== 4'h0 || digit_valid !== 1'b0 || change_pulse !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_display: seg_code=%h digit=%h valid=%b pulse=%b, required 00 0 0 0",
                  seg_code, digit, digit_valid, change_pulse);
      end
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (change_pulse) pulses++;
      end
      compared++;
      if (pulses !== 0) begin
         mismatched++;
         $display("FAIL idle_no_pulse: got %0d pulses, required 0", pulses);
      end
      compared++;
      if (interval !== 24'd0 || interval_valid !== 1'b0 || interval_sat !== 1'b0 || change_count !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_counters: interval=%0d ivalid=%b sat=%b count=%0d, required 0 0 0 0",
                  interval, interval_valid, interval_sat, change_count);
      end
   endtask

   task automatic test_first_accept();
      int edges;
      segments_in = 7'h3F;
      wait_pulse(50, edges);
      compared++;
      if (edges !== 5) begin
         mismatched++;
         $display("FAIL first_latency: pulse after %0d edges, required 5", edges);
      end
      compared++;
      if (seg_code !== 7'h3F || digit !== 4'h0 || digit_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL first_decode: seg_code=%h digit=%h valid=%b, required 3f 0 1",
                  seg_code, digit, digit_valid);
      end
      compared++;
      if (interval_valid !== 1'b0 || interval !== 24'd0 || change_count !== 16'd1) begin
         mismatched++;
         $display("FAIL first_interval: ivalid=%b interval=%0d count=%0d, required 0 0 1",
                  interval_valid, interval, change_count);
      end
      @(negedge clk);
      compared++;
      if (change_pulse !== 1'b0) begin
         mismatched++;
         $display("FAIL pulse_width: pulse=%b one cycle later, required 0", change_pulse);
      end
   endtask

   task automatic test_interval();
      int edges;
      repeat (3) @(negedge clk);
      segments_in = 7'h06;
      t_drive = cyc;
      wait_pulse(50, edges);
      compared++;
      if (edges !== 5 || digit !== 4'h1 || interval_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL second_accept: edges=%0d digit=%h ivalid=%b, required 5 1 1",
                  edges, digit, interval_valid);
      end
      while (cyc < t_drive + 100) @(negedge clk);
      segments_in = 7'h5B;
      wait_pulse(50, edges);
      compared++;
      if (interval !== 24'd100 || interval_valid !== 1'b1 || interval_sat !== 1'b0) begin
         mismatched++;
         $display("FAIL interval_100: interval=%0d ivalid=%b sat=%b, required 100 1 0",
                  interval, interval_valid, interval_sat);
      end
      compared++;
      if (digit !== 4'h2 || seg_code !== 7'h5B || change_count !== 16'd3) begin
         mismatched++;
         $display("FAIL third_accept: digit=%h seg_code=%h count=%0d, required 2 5b 3",
                  digit, seg_code, change_count);
      end
      compared++;
      if (n_interval !== 8'd100 || n_interval_sat !== 1'b0) begin
         mismatched++;
         $display("FAIL narrow_interval_100: interval=%0d sat=%b, required 100 0",
                  n_interval, n_interval_sat);
      end
   endtask

   task automatic test_glitch();
      int edges;
      int pulses;
      repeat (5) @(negedge clk);
      segments_in = 7'h7F;
      repeat (3) @(negedge clk);
      segments_in = 7'h5B;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (change_pulse) pulses++;
      end
      compared++;
      if (pulses !== 0 || seg_code !== 7'h5B || change_count !== 16'd3) begin
         mismatched++;
         $display("FAIL glitch_3: pulses=%0d seg_code=%h count=%0d, required 0 5b 3",
                  pulses, seg_code, change_count);
      end
      segments_in = 7'h7F;
      t_drive = cyc;
      wait_pulse(50, edges);
      compared++;
      if (edges !== 5 || digit !== 4'h8 || digit_valid !== 1'b1 || change_count !== 16'd4) begin
         mismatched++;
         $display("FAIL glitch_4_accept: edges=%0d digit=%h valid=%b count=%0d, required 5 8 1 4",
                  edges, digit, digit_valid, change_count);
      end
   endtask

   task automatic test_invalid_sat();
      int edges;
      while (cyc < t_drive + 300) @(negedge clk);
      segments_in = 7'h40;
      wait_pulse(50, edges);
      compared++;
      if (edges !== 5 || seg_code !== 7'h40 || digit !== 4'h0 || digit_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL invalid_glyph: edges=%0d seg_code=%h digit=%h valid=%b, required 5 40 0 0",
                  edges, seg_code, digit, digit_valid);
      end
      compared++;
      if (interval !== 24'd300 || interval_sat !== 1'b0 || change_count !== 16'd5) begin
         mismatched++;
         $display("FAIL interval_300: interval=%0d sat=%b count=%0d, required 300 0 5",
                  interval, interval_sat, change_count);
      end
      compared++;
      if (n_interval !== 8'd255 || n_interval_sat !== 1'b1 || n_interval_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL narrow_saturate: interval=%0d sat=%b ivalid=%b, required 255 1 1",
                  n_interval, n_interval_sat, n_interval_valid);
      end
      compared++;
      if (n_change_count !== 2'd1) begin
         mismatched++;
         $display("FAIL narrow_count_wrap: count=%0d, required 1", n_change_count);
      end
   endtask

   task automatic test_reset_mid_filter();
      int edges;
      repeat (4) @(negedge clk);
      segments_in = 7'h3F;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if (seg_code !== 7'h00 || digit_valid !== 1'b0 || interval !== 24'd0 ||
          interval_valid !== 1'b0 || interval_sat !== 1'b0 || change_count !== 16'd0) begin
         mismatched++;
         $display("FAIL async_reset: seg_code=%h valid=%b interval=%0d ivalid=%b sat=%b count=%0d, required all 0",
                  seg_code, digit_valid, interval, interval_valid, interval_sat, change_count);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_pulse(50, edges);
      compared++;
      if (edges !== 5 || seg_code !== 7'h3F || change_count !== 16'd1 || interval_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_accept: edges=%0d seg_code=%h count=%0d ivalid=%b, required 5 3f 1 0",
                  edges, seg_code, change_count, interval_valid);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      t_drive = 0;
      rst_n = 1'b0;
      segments_in = 7'h00;
      test_reset();
      test_first_accept();
      test_interval();
      test_glitch();
      test_invalid_sat();
      test_reset_mid_filter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
